// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: register offsets, STATUS bit positions and FSM encoding shared by spi_slave.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
package spi_slave_pkg;
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_TXDATA = 4'h8;
    localparam logic [3:0] ADDR_RXDATA = 4'hC;
    localparam int ST_RX_EMPTY   = 0;
    localparam int ST_RX_FULL    = 1;
    localparam int ST_RX_OVF     = 2;
    localparam int ST_SELECTED   = 3;
    localparam int ST_TX_PENDING = 4;
    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;
endpackage

// File: rtl/spi_slave_rx_fifo.sv
// spi_slave_rx_fifo: synchronous byte FIFO; pops on empty are ignored, a push while full
// only lands when a pop frees the slot in the same cycle.
module spi_slave_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == (AW+1)'(DEPTH);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head    = mem_q[rd_q];
        count   = cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder (8-bit, MSB first) with RX FIFO and TX holding register.
// Define SPI_SLAVE_IRQ_EN to add CTRL RXIE/OVFIE and drive int_sig_o.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [`CPU_WIDTH-1:0] addr_i,
    input  logic [`CPU_WIDTH-1:0] data_i,
    output logic [`CPU_WIDTH-1:0] data_o,
    input  logic                  spi_clk,
    input  logic                  spi_ss,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  int_sig_o
);
    localparam int DW = `CPU_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef SPI_SLAVE_IRQ_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b001;
`endif
    state_e          state_q, state_d;
    logic [2:0]      sclk_q, sclk_d, ss_q, ss_d, ctrl_q, ctrl_d, bit_cnt_q, bit_cnt_d;
    logic [1:0]      mosi_q, mosi_d;
    logic [7:0]      shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d, tx_buf_q, tx_buf_d;
    logic            tx_pend_q, tx_pend_d, ovf_q, ovf_d, push_q, push_d;
    logic            miso_q, miso_d, oe_q, oe_d;
    logic            sclk_rise, sclk_fall, ss_fall, ss_rise, load, pop, tx_wr;
    logic [3:0]      reg_addr;
    logic [7:0]      head;
    logic            full, empty;
    logic [CW-1:0]   count;
    logic [15:0]     status;
    logic            unused_bits;

    assign unused_bits = ^{addr_i[DW-1:4], data_i[DW-1:8]};

    spi_slave_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (pop),
        .wdata (shift_rx_q),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        sclk_d    = {sclk_q[1:0], spi_clk};
        ss_d      = {ss_q[1:0], spi_ss};
        mosi_d    = {mosi_q[0], spi_mosi};
        sclk_rise = sclk_q[1] & ~sclk_q[2];
        sclk_fall = ~sclk_q[1] & sclk_q[2];
        ss_fall   = ~ss_q[1] & ss_q[2];
        ss_rise   = ss_q[1] & ~ss_q[2];
        reg_addr  = addr_i[3:0];
        pop       = we_i && reg_addr == ADDR_RXDATA;
        tx_wr     = we_i && reg_addr == ADDR_TXDATA;
        ctrl_d    = (we_i && reg_addr == ADDR_CTRL) ? data_i[2:0] & CTRL_MASK : ctrl_q;
        ovf_d     = (push_q & full & ~pop)
                  | (ovf_q & ~(we_i && reg_addr == ADDR_STATUS && data_i[ST_RX_OVF]));
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_rx_d = shift_rx_q;
        shift_tx_d = shift_tx_q;
        push_d     = 1'b0;
        load       = 1'b0;
        if (state_q == S_IDLE) begin
            if (ss_fall && ctrl_q[0]) begin
                state_d   = S_ACTIVE;
                bit_cnt_d = '0;
                load      = 1'b1;
            end
        end else if (ss_rise || !ctrl_q[0]) begin
            state_d = S_IDLE;
        end else if (sclk_rise) begin
            // 3-bit counter wraps 7->0 as the eighth bit lands
            shift_rx_d = {shift_rx_q[6:0], mosi_q[1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            push_d     = bit_cnt_q == 3'd7;
            load       = bit_cnt_q == 3'd7;
        end else if (sclk_fall && bit_cnt_q != '0) begin
            shift_tx_d = {shift_tx_q[6:0], 1'b0};
        end
        if (load) shift_tx_d = tx_pend_q ? tx_buf_q : IDLE_BYTE;
        tx_buf_d  = tx_wr ? data_i[7:0] : tx_buf_q;
        tx_pend_d = tx_wr | (tx_pend_q & ~load);
        oe_d      = state_d == S_ACTIVE;
        miso_d    = oe_d & shift_tx_d[7];
    end

    always_comb begin
        status                = '0;
        status[ST_RX_EMPTY]   = empty;
        status[ST_RX_FULL]    = full;
        status[ST_RX_OVF]     = ovf_q;
        status[ST_SELECTED]   = state_q == S_ACTIVE;
        status[ST_TX_PENDING] = tx_pend_q;
        status[15:8]          = 8'(count);
        data_o = (reg_addr == ADDR_CTRL)             ? DW'(ctrl_q) :
                 (reg_addr == ADDR_STATUS)           ? DW'(status) :
                 (reg_addr == ADDR_RXDATA && !empty) ? DW'(head)   : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sclk_q     <= '0;
            ss_q       <= '1;
            mosi_q     <= '0;
            ctrl_q     <= '0;
            bit_cnt_q  <= '0;
            shift_rx_q <= '0;
            shift_tx_q <= '0;
            tx_buf_q   <= '0;
            tx_pend_q  <= 1'b0;
            ovf_q      <= 1'b0;
            push_q     <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            ctrl_q     <= ctrl_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_rx_q <= shift_rx_d;
            shift_tx_q <= shift_tx_d;
            tx_buf_q   <= tx_buf_d;
            tx_pend_q  <= tx_pend_d;
            ovf_q      <= ovf_d;
            push_q     <= push_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;

`ifdef SPI_SLAVE_IRQ_EN
    logic int_q, int_d, empty_next;
    // use next-cycle FIFO/ovf state so a pop or W1C drops the line on the same edge
    always_comb begin
        empty_next = (empty | ((count == CW'(1)) & pop)) & ~push_q;
        int_d      = (ctrl_d[1] & ~empty_next) | (ctrl_d[2] & ovf_d);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_q <= 1'b0;
        else        int_q <= int_d;
    end
    assign int_sig_o = int_q;
`else
    assign int_sig_o = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master plus a queue-based model of the RX FIFO and TX buffer.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
module tb_spi_slave;
    localparam int DW    = `CPU_WIDTH;
    localparam int DEPTH = 8;
    localparam int HALF  = 5;

    logic          clk = 1'b0, rst_n = 1'b0, we_i = 1'b0;
    logic [DW-1:0] addr_i = '0, data_i = '0, data_o;
    logic          spi_clk = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
    logic          spi_miso, spi_miso_oe, int_sig_o;

    int         errors = 0, checks = 0;
    logic [7:0] exp_q[$];
    logic       exp_pend = 1'b0, exp_ovf = 1'b0;
    logic [7:0] exp_buf = '0;

    spi_slave #(.FIFO_DEPTH(DEPTH), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o), .spi_clk(spi_clk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .int_sig_o(int_sig_o)
    );

    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        we_i = 1'b1; addr_i = a; data_i = d;
        @(negedge clk);
        we_i = 1'b0;
        if (a[3:0] == 4'h8) begin exp_pend = 1'b1; exp_buf = d[7:0]; end
        if (a[3:0] == 4'hC && exp_q.size() > 0) void'(exp_q.pop_front());
        if (a[3:0] == 4'h4 && d[2]) exp_ovf = 1'b0;
    endtask

    task automatic bus_rd(input logic [DW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        addr_i = a;
        #1 d = data_o;
    endtask

    function automatic logic [DW-1:0] exp_status(input logic sel);
        int n = exp_q.size();
        return DW'({8'(n), 3'b000, exp_pend, sel, exp_ovf, n == DEPTH, n == 0});
    endfunction

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            clks(HALF);
            spi_clk = 1'b1;
            rx = {rx[6:0], spi_miso};
            clks(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic ss_hi();
        clks(HALF);
        spi_ss = 1'b1;
        clks(6);
    endtask

    task automatic frame(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] want);
        want = exp_pend ? exp_buf : 8'hFF;
        exp_pend = 1'b0;
        spi_ss = 1'b0;
        clks(6);
        xfer(tx, 8, rx);
        model_push(tx);
        ss_hi();
    endtask

    task automatic drain(input string tag);
        logic [DW-1:0] d;
        while (exp_q.size() > 0) begin
            bus_rd(32'hC, d);
            checks++;
            if (d !== DW'(exp_q[0])) begin
                errors++;
                $display("FAIL %s_drain got %h want %h", tag, d, exp_q[0]);
            end
            bus_wr(32'hC, 0);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        clks(3);
        rst_n = 1'b1;
        clks(2);
        checks++;
        if ({spi_miso, spi_miso_oe, int_sig_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000", {spi_miso, spi_miso_oe, int_sig_o});
        end
        bus_rd(32'h4, d);
        checks++;
        if (d !== exp_status(1'b0)) begin errors++; $display("FAIL reset_status got %h want %h", d, exp_status(1'b0)); end
        bus_rd(32'h0, d);
        checks++;
        if (d !== '0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
        bus_rd(32'hC, d);
        checks++;
        if (d !== '0) begin errors++; $display("FAIL reset_rxdata got %h want 0", d); end
        bus_wr(32'hC, 0);
        bus_rd(32'h4, d);
        checks++;
        if (d !== exp_status(1'b0)) begin errors++; $display("FAIL empty_pop got %h want %h", d, exp_status(1'b0)); end
        bus_rd(32'h3, d);
        checks++;
        if (d !== '0) begin errors++; $display("FAIL unmapped got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d;
        logic [7:0] rx;
        bus_wr(32'h0, 32'h1);
        bus_wr(32'h8, 32'hA5);
        bus_rd(32'h8, d);
        checks++;
        if (d !== '0) begin errors++; $display("FAIL txdata_read got %h want 0", d); end
        bus_rd(32'h4, d);
        checks++;
        if (d !== exp_status(1'b0)) begin errors++; $display("FAIL basic_pending got %h want %h", d, exp_status(1'b0)); end
        exp_pend = 1'b0;
        spi_ss = 1'b0;
        clks(6);
        bus_rd(32'h4, d);
        checks++;
        if (spi_miso_oe !== 1'b1 || d !== exp_status(1'b1)) begin
            errors++;
            $display("FAIL basic_selected got oe=%b st=%h want oe=1 st=%h", spi_miso_oe, d, exp_status(1'b1));
        end
        xfer(8'h3C, 8, rx);
        model_push(8'h3C);
        ss_hi();
        checks++;
        if (rx !== 8'hA5) begin errors++; $display("FAIL basic_miso got %h want a5", rx); end
        bus_rd(32'hC, d);
        checks++;
        if (d !== DW'(8'h3C)) begin errors++; $display("FAIL basic_rxdata got %h want 3c", d); end
        bus_rd(32'h4, d);
        checks++;
        if (d !== exp_status(1'b0)) begin errors++; $display("FAIL basic_status got %h want %h", d, exp_status(1'b0)); end
        drain("basic");
    endtask

    task automatic test_idle_bytes();
        logic [7:0] rx, want;
        for (int i = 0; i < 2; i++) begin
            frame(8'($urandom), rx, want);
            checks++;
            if (rx !== 8'hFF || want !== 8'hFF) begin errors++; $display("FAIL idle_byte%0d got %h want ff", i, rx); end
        end
        drain("idle");
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic [7:0] rx, want;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1, 0) == 1) bus_wr(32'h8, DW'($urandom_range(255, 0)));
            frame(8'($urandom), rx, want);
            checks++;
            if (rx !== want) begin errors++; $display("FAIL rand_miso%0d got %h want %h", i, rx, want); end
            bus_rd(32'h4, d);
            checks++;
            if (d !== exp_status(1'b0)) begin errors++; $display("FAIL rand_status%0d got %h want %h", i, d, exp_status(1'b0)); end
            if ($urandom_range(1, 0) == 1) begin
                bus_rd(32'hC, d);
                checks++;
                if (d !== DW'(exp_q[0])) begin errors++; $display("FAIL rand_head%0d got %h want %h", i, d, exp_q[0]); end
                bus_wr(32'hC, 0);
            end
        end
        drain("rand");
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d;
        logic [7:0] rx, want, first;
        first = 8'($urandom);
        frame(first, rx, want);
        for (int i = 0; i < DEPTH; i++) frame(8'($urandom), rx, want);
        bus_rd(32'h4, d);
        checks++;
        if (d[2:1] !== 2'b11 || d !== exp_status(1'b0)) begin
            errors++;
            $display("FAIL ovf_status got %h want %h", d, exp_status(1'b0));
        end
        bus_rd(32'hC, d);
        checks++;
        if (d !== DW'(first)) begin errors++; $display("FAIL ovf_head got %h want %h", d, first); end
        bus_wr(32'hC, 0);
        bus_rd(32'h4, d);
        checks++;
        if (d[2] !== 1'b1 || d !== exp_status(1'b0)) begin errors++; $display("FAIL ovf_sticky got %h want %h", d, exp_status(1'b0)); end
        bus_wr(32'h4, 32'h4);
        bus_rd(32'h4, d);
        checks++;
        if (d[2] !== 1'b0 || d !== exp_status(1'b0)) begin errors++; $display("FAIL ovf_clear got %h want %h", d, exp_status(1'b0)); end
        drain("ovf");
    endtask

    task automatic test_partial();
        logic [DW-1:0] d;
        logic [7:0] rx, want;
        frame(8'($urandom), rx, want);
        exp_pend = 1'b0;
        spi_ss = 1'b0;
        clks(6);
        xfer(8'($urandom), 5, rx);
        ss_hi();
        bus_rd(32'h4, d);
        checks++;
        if (d !== exp_status(1'b0)) begin errors++; $display("FAIL partial_status got %h want %h", d, exp_status(1'b0)); end
        frame(8'h81, rx, want);
        bus_rd(32'h4, d);
        checks++;
        if (d[15:8] !== 8'd2) begin errors++; $display("FAIL partial_count got %0d want 2", d[15:8]); end
        bus_wr(32'hC, 0);
        bus_rd(32'hC, d);
        checks++;
        if (d !== DW'(8'h81)) begin errors++; $display("FAIL partial_next got %h want 81", d); end
        drain("partial");
    endtask

    task automatic test_abort_en();
        logic [DW-1:0] d;
        logic [7:0] rx;
        bus_wr(32'h8, 32'h5A);
        exp_pend = 1'b0;
        spi_ss = 1'b0;
        clks(6);
        xfer(8'($urandom), 3, rx);
        bus_wr(32'h0, 32'h0);
        clks(2);
        bus_rd(32'h4, d);
        checks++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || d !== exp_status(1'b0)) begin
            errors++;
            $display("FAIL abort_en got oe=%b miso=%b st=%h want 0 0 %h", spi_miso_oe, spi_miso, d, exp_status(1'b0));
        end
        xfer(8'($urandom), 5, rx);
        ss_hi();
        bus_rd(32'h4, d);
        checks++;
        if (d !== exp_status(1'b0)) begin errors++; $display("FAIL abort_en_nopush got %h want %h", d, exp_status(1'b0)); end
        bus_wr(32'h0, 32'h1);
    endtask

    task automatic test_abort_reset();
        logic [DW-1:0] d;
        logic [7:0] rx, want;
        frame(8'($urandom), rx, want);
        spi_ss = 1'b0;
        clks(6);
        xfer(8'($urandom), 4, rx);
        rst_n = 1'b0;
        #1;
        checks++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst_oe got oe=%b miso=%b want 0 0", spi_miso_oe, spi_miso);
        end
        clks(2);
        rst_n = 1'b1;
        exp_q.delete();
        exp_pend = 1'b0;
        exp_ovf = 1'b0;
        ss_hi();
        bus_rd(32'h4, d);
        checks++;
        if (d !== exp_status(1'b0)) begin errors++; $display("FAIL abort_rst_status got %h want %h", d, exp_status(1'b0)); end
        bus_wr(32'h0, 32'h1);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [7:0] a, b, rx0, rx1, tx;
        a = 8'($urandom);
        b = 8'($urandom);
        tx = 8'($urandom);
        bus_wr(32'h8, DW'(tx));
        exp_pend = 1'b0;
        spi_ss = 1'b0;
        clks(6);
        xfer(a, 8, rx0);
        model_push(a);
        xfer(b, 8, rx1);
        model_push(b);
        ss_hi();
        checks++;
        if (rx0 !== tx || rx1 !== 8'hFF) begin errors++; $display("FAIL b2b_miso got %h %h want %h ff", rx0, rx1, tx); end
        bus_rd(32'h4, d);
        checks++;
        if (d !== exp_status(1'b0)) begin errors++; $display("FAIL b2b_status got %h want %h", d, exp_status(1'b0)); end
        drain("b2b");
    endtask

    task automatic test_irq();
        logic [DW-1:0] d;
        logic [7:0] rx, want;
`ifdef SPI_SLAVE_IRQ_EN
        bus_wr(32'h0, 32'h3);
        frame(8'($urandom), rx, want);
        checks++;
        if (int_sig_o !== 1'b1) begin errors++; $display("FAIL irq_rx got %b want 1", int_sig_o); end
        @(negedge clk);
        we_i = 1'b1; addr_i = 32'hC;
        @(negedge clk);
        we_i = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (int_sig_o !== 1'b0) begin errors++; $display("FAIL irq_pop got %b want 0", int_sig_o); end
        bus_wr(32'h0, 32'h5);
        for (int i = 0; i <= DEPTH; i++) frame(8'($urandom), rx, want);
        checks++;
        if (int_sig_o !== 1'b1) begin errors++; $display("FAIL irq_ovf got %b want 1", int_sig_o); end
        bus_wr(32'h4, 32'h4);
        checks++;
        if (int_sig_o !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b want 0", int_sig_o); end
        drain("irq");
        bus_wr(32'h0, 32'h1);
`else
        bus_wr(32'h0, 32'h7);
        bus_rd(32'h0, d);
        checks++;
        if (d !== DW'(1)) begin errors++; $display("FAIL ctrl_mask got %h want 1", d); end
        frame(8'($urandom), rx, want);
        checks++;
        if (int_sig_o !== 1'b0) begin errors++; $display("FAIL irq_tied got %b want 0", int_sig_o); end
        drain("irq");
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_bytes();
        test_random();
        test_overflow();
        test_partial();
        test_abort_en();
        test_abort_reset();
        test_back_to_back();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
